// File: rtl/ad_capture_sched.sv
// Frame sequencer for the AD capture -> FIFO -> Avalon-ST DMA -> DDR3 ring path.
// Each frame posts one DMA descriptor, arms the AD source, waits for both completions, then advances the ring.
`timescale 1ns/1ps
module ad_capture_sched #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000,
  parameter logic [7:0]  GAP_CYCLES     = 8'd16,
  parameter logic [3:0]  STATUS_WAIT    = 4'd2,
  parameter logic [3:0]  STATUS_IDLE    = 4'd0
) (
  input  logic        clk_200m,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [15:0] cfg_frames,
  input  logic [15:0] cfg_length,
  input  logic [31:0] cfg_base_addr,
  input  logic [7:0]  cfg_ring_slots,
  output logic [7:0]  ad_control,
  output logic [15:0] ad_length,
  input  logic [3:0]  ad_status,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [31:0] desc_addr,
  output logic [31:0] desc_bytes,
  input  logic        dma_done,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  slot_idx,
  output logic [1:0]  err,
  output logic        irq
);

  // state | meaning
  // IDLE  | waiting for cfg_start
  // DESC  | descriptor offered to the DMA, waiting for desc_ready
  // RUN   | AD armed, waiting for AD WAIT status plus DMA completion
  // STOP  | AD disarmed, waiting for AD idle status
  // GAP   | enforced idle gap before the next frame or the end of the run
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DESC = 3'd1,
    S_RUN  = 3'd2,
    S_STOP = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  // One down-counter serves both the RUN timeout and the GAP delay.
  localparam logic [23:0] TMO_LOAD = (TIMEOUT_CYCLES == 24'd0) ? 24'd0 : TIMEOUT_CYCLES - 24'd1;
  localparam logic [23:0] GAP_LOAD = (GAP_CYCLES == 8'd0) ? 24'd0 : {16'd0, GAP_CYCLES - 8'd1};

  state_t      state_q, state_d;
  logic [15:0] length_q, length_d;
  logic [15:0] frames_q, frames_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] ad_len_q, ad_len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  slots_q, slots_d;
  logic [7:0]  slot_q, slot_d;
  logic [1:0]  err_q, err_d;
  logic        irq_q, irq_d;
  logic        abort_q, abort_d;
  logic        done_seen_q, done_seen_d;
  logic [23:0] tmr_q, tmr_d;

  logic [31:0] frame_bytes;
  logic        run_exit;
  logic        ring_wrap;
  logic        end_run;

  assign frame_bytes = {14'b0, length_q, 2'b00};
  assign run_exit    = (ad_status == STATUS_WAIT) && (done_seen_q || dma_done);
  assign ring_wrap   = ({1'b0, slot_q} + 9'd1) == {1'b0, slots_q};
  assign end_run     = (err_q != 2'b00) || abort_q || cfg_abort ||
                       ((frames_q != 16'd0) && (frame_cnt_q == frames_q));

  always_ff @(posedge clk_200m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      length_q    <= 16'd0;
      frames_q    <= 16'd0;
      frame_cnt_q <= 16'd0;
      ad_len_q    <= 16'd0;
      base_q      <= 32'd0;
      addr_q      <= 32'd0;
      slots_q     <= 8'd0;
      slot_q      <= 8'd0;
      err_q       <= 2'b00;
      irq_q       <= 1'b0;
      abort_q     <= 1'b0;
      done_seen_q <= 1'b0;
      tmr_q       <= 24'd0;
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      frames_q    <= frames_d;
      frame_cnt_q <= frame_cnt_d;
      ad_len_q    <= ad_len_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      slots_q     <= slots_d;
      slot_q      <= slot_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      abort_q     <= abort_d;
      done_seen_q <= done_seen_d;
      tmr_q       <= tmr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    length_d    = length_q;
    frames_d    = frames_q;
    frame_cnt_d = frame_cnt_q;
    ad_len_d    = ad_len_q;
    base_d      = base_q;
    addr_d      = addr_q;
    slots_d     = slots_q;
    slot_d      = slot_q;
    err_d       = err_q;
    irq_d       = 1'b0;
    abort_d     = abort_q;
    done_seen_d = done_seen_q;
    tmr_d       = tmr_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          err_d       = 2'b00;
          frame_cnt_d = 16'd0;
          slot_d      = 8'd0;
          base_d      = cfg_base_addr & 32'hFFFF_FFFC;
          addr_d      = cfg_base_addr & 32'hFFFF_FFFC;
          length_d    = cfg_length;
          frames_d    = cfg_frames;
          slots_d     = (cfg_ring_slots == 8'd0) ? 8'd1 : cfg_ring_slots;
          if (cfg_length == 16'd0) begin
            err_d = 2'b01;
            irq_d = 1'b1;
          end else begin
            ad_len_d = cfg_length - 16'd1;
            state_d  = S_DESC;
          end
        end
      end

      S_DESC: begin
        if (cfg_abort) abort_d = 1'b1;
        if (desc_ready) begin
          done_seen_d = 1'b0;
          tmr_d       = TMO_LOAD;
          state_d     = S_RUN;
        end
      end

      S_RUN: begin
        if (cfg_abort) abort_d = 1'b1;
        if (dma_done) done_seen_d = 1'b1;
        // A completed frame wins over a timeout expiring in the same cycle.
        if (run_exit) begin
          if (frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
          state_d = S_STOP;
        end else if (tmr_q == 24'd0) begin
          err_d   = 2'b10;
          state_d = S_STOP;
        end else begin
          tmr_d = tmr_q - 24'd1;
        end
      end

      S_STOP: begin
        if (cfg_abort) abort_d = 1'b1;
        if (ad_status == STATUS_IDLE) begin
          tmr_d   = GAP_LOAD;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (cfg_abort) abort_d = 1'b1;
        if (tmr_q != 24'd0) begin
          tmr_d = tmr_q - 24'd1;
        end else if (end_run) begin
          abort_d = 1'b0;
          irq_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (ring_wrap) begin
            slot_d = 8'd0;
            addr_d = base_q;
          end else begin
            slot_d = slot_q + 8'd1;
            addr_d = addr_q + frame_bytes;
          end
          state_d = S_DESC;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign ad_control = {7'b0, (state_q == S_RUN)};
  assign ad_length  = ad_len_q;
  assign desc_valid = (state_q == S_DESC);
  assign desc_addr  = addr_q;
  assign desc_bytes = frame_bytes;
  assign frame_cnt  = frame_cnt_q;
  assign slot_idx   = slot_q;
  assign err        = err_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_ad_capture_sched.sv
// Bench for ad_capture_sched: AD source, DMA and descriptor-sink models plus per-scenario checks
// against ring addresses computed directly from the run configuration.
`timescale 1ns/1ps
module tb_ad_capture_sched;

  localparam int GAP = 16;

  logic        clk_200m = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start, cfg_abort;
  logic [15:0] cfg_frames, cfg_length;
  logic [31:0] cfg_base_addr;
  logic [7:0]  cfg_ring_slots;
  logic [7:0]  ad_control;
  logic [15:0] ad_length;
  logic [3:0]  ad_status;
  logic        desc_valid, desc_ready;
  logic [31:0] desc_addr, desc_bytes;
  logic        dma_done, busy, irq;
  logic [15:0] frame_cnt;
  logic [7:0]  slot_idx;
  logic [1:0]  err;

  int n_checks = 0;
  int n_fail = 0;

  // model configuration (written by tests) and observations (written by the model loop)
  int rdy_delay = 0, dma_mode = 1, ad_busy_len = 0;
  int cyc = 0, irq_cnt = 0, run_cyc = 0, valid_cyc = 0;
  int stab_viol = 0, gap_viol = 0, idle_t = -1;
  logic [15:0] last_ad_len = '0;
  logic [31:0] mon_addr[$];
  logic [31:0] mon_bytes[$];
  logic [7:0]  mon_slot[$];

  ad_capture_sched #(
    .TIMEOUT_CYCLES(24'd100),
    .GAP_CYCLES(8'd16),
    .STATUS_WAIT(4'd2),
    .STATUS_IDLE(4'd0)
  ) dut (
    .clk_200m(clk_200m), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_frames(cfg_frames), .cfg_length(cfg_length), .cfg_base_addr(cfg_base_addr),
    .cfg_ring_slots(cfg_ring_slots), .ad_control(ad_control), .ad_length(ad_length),
    .ad_status(ad_status), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_bytes(desc_bytes), .dma_done(dma_done), .busy(busy),
    .frame_cnt(frame_cnt), .slot_idx(slot_idx), .err(err), .irq(irq)
  );

  initial forever #2.5 clk_200m = ~clk_200m;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // AD source, DMA engine and descriptor sink, all driven on the falling edge
  initial begin
    int ad_cnt, dma_cnt, rdy_cnt;
    logic prev_valid, prev_ready;
    logic [31:0] prev_addr;
    ad_cnt = 0; dma_cnt = 0; rdy_cnt = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_addr = '0;
    ad_status = 4'd0; desc_ready = 1'b0; dma_done = 1'b0;
    forever begin
      @(negedge clk_200m);
      cyc++;
      if (irq) irq_cnt++;
      if (ad_control[0]) begin run_cyc++; last_ad_len = ad_length; end
      if (desc_valid) valid_cyc++;
      if (prev_valid && !prev_ready && rst_n && (desc_valid !== 1'b1 || desc_addr !== prev_addr))
        stab_viol++;
      if (desc_valid && !prev_valid && idle_t >= 0 && (cyc - idle_t) <= GAP) gap_viol++;

      if (desc_valid) begin
        desc_ready = (rdy_cnt >= rdy_delay);
        rdy_cnt++;
        if (desc_ready) begin
          mon_addr.push_back(desc_addr);
          mon_bytes.push_back(desc_bytes);
          mon_slot.push_back(slot_idx);
        end
      end else begin
        desc_ready = 1'b0;
        rdy_cnt = 0;
      end
      prev_valid = desc_valid; prev_ready = desc_ready; prev_addr = desc_addr;

      dma_done = 1'b0;
      if (dma_cnt > 0) begin
        dma_cnt--;
        if (dma_cnt == 0) dma_done = 1'b1;
      end

      case (ad_status)
        4'd0: if (ad_control[0]) begin
          ad_status = 4'd1;
          ad_cnt = (ad_busy_len > 0) ? ad_busy_len : int'($urandom_range(3, 20));
          if (dma_mode == 2) dma_cnt = 2;
        end
        4'd1: if (!ad_control[0]) begin
          ad_status = 4'd3; ad_cnt = 2;
        end else if (ad_cnt == 0) begin
          ad_status = 4'd2;
          if (dma_mode == 1) dma_cnt = 5;
        end else ad_cnt--;
        4'd2: if (!ad_control[0]) begin ad_status = 4'd3; ad_cnt = 2; end
        default: if (ad_cnt == 0) begin ad_status = 4'd0; idle_t = cyc; end else ad_cnt--;
      endcase
    end
  end

  function automatic logic [31:0] ref_addr(input logic [31:0] base, input int slots, input int len, input int k);
    int s;
    s = (slots == 0) ? 1 : slots;
    return (base & 32'hFFFF_FFFC) + 32'((k % s) * len * 4);
  endfunction

  function automatic logic [7:0] ref_slot(input int slots, input int k);
    int s;
    s = (slots == 0) ? 1 : slots;
    return 8'(k % s);
  endfunction

  task automatic start_run(input logic [15:0] f, input logic [15:0] l, input logic [31:0] b, input logic [7:0] s);
    @(negedge clk_200m);
    cfg_frames = f; cfg_length = l; cfg_base_addr = b; cfg_ring_slots = s; cfg_start = 1'b1;
    @(negedge clk_200m);
    cfg_start = 1'b0;
    cfg_frames = 16'($urandom); cfg_length = 16'($urandom);
    cfg_base_addr = $urandom; cfg_ring_slots = 8'($urandom);
  endtask

  task automatic pulse_abort();
    @(negedge clk_200m); cfg_abort = 1'b1;
    @(negedge clk_200m); cfg_abort = 1'b0;
  endtask

  task automatic wait_irq(input int i0, input int budget);
    for (int i = 0; i < budget && irq_cnt == i0; i++) @(negedge clk_200m);
    repeat (4) @(negedge clk_200m);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_200m);
    n_checks++; if (busy !== 1'b0 || desc_valid !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy/valid/irq got %b%b%b, expected 000", busy, desc_valid, irq); end
    n_checks++; if (ad_control !== 8'h00) begin
      n_fail++; $display("FAIL reset_ad_control: got %h, expected 00", ad_control); end
    n_checks++; if (err !== 2'b00 || frame_cnt !== 16'd0 || slot_idx !== 8'd0) begin
      n_fail++; $display("FAIL reset_counters: err=%b frame_cnt=%0d slot=%0d, expected 0", err, frame_cnt, slot_idx); end
    n_checks++; if (desc_addr !== 32'd0 || desc_bytes !== 32'd0 || ad_length !== 16'd0) begin
      n_fail++; $display("FAIL reset_data: addr=%h bytes=%h ad_length=%h, expected 0", desc_addr, desc_bytes, ad_length); end
    @(negedge clk_200m); rst_n = 1'b1;
    repeat (3) @(negedge clk_200m);
  endtask

  task automatic test_normal();
    int i0, d0;
    i0 = irq_cnt; d0 = mon_addr.size();
    rdy_delay = 0; dma_mode = 1; ad_busy_len = 0;
    pulse_abort();
    start_run(16'd3, 16'd256, 32'h1000_0000, 8'd4);
    wait_irq(i0, 3000);
    n_checks++; if (mon_addr.size() !== d0 + 3) begin
      n_fail++; $display("FAIL normal_desc_count: got %0d, expected 3", mon_addr.size() - d0); end
    for (int k = 0; k < 3 && d0 + k < mon_addr.size(); k++) begin
      n_checks++; if (mon_addr[d0+k] !== ref_addr(32'h1000_0000, 4, 256, k) || mon_bytes[d0+k] !== 32'd1024) begin
        n_fail++; $display("FAIL normal_desc%0d: got (%h,%0d), expected (%h,1024)", k, mon_addr[d0+k],
                           mon_bytes[d0+k], ref_addr(32'h1000_0000, 4, 256, k)); end
    end
    n_checks++; if (last_ad_len !== 16'd255) begin
      n_fail++; $display("FAIL normal_ad_length: got %0d, expected 255", last_ad_len); end
    n_checks++; if (frame_cnt !== 16'd3 || err !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL normal_end: frame_cnt=%0d err=%b busy=%b, expected 3 00 0", frame_cnt, err, busy); end
    n_checks++; if (irq_cnt !== i0 + 1) begin
      n_fail++; $display("FAIL normal_irq: got %0d pulses, expected 1", irq_cnt - i0); end
  endtask

  task automatic test_ring_wrap();
    int i0, d0;
    i0 = irq_cnt; d0 = mon_addr.size();
    rdy_delay = 1; dma_mode = 1; ad_busy_len = 0;
    start_run(16'd5, 16'd16, 32'h0, 8'd2);
    wait_irq(i0, 4000);
    n_checks++; if (mon_addr.size() !== d0 + 5) begin
      n_fail++; $display("FAIL ring_desc_count: got %0d, expected 5", mon_addr.size() - d0); end
    for (int k = 0; k < 5 && d0 + k < mon_addr.size(); k++) begin
      n_checks++; if (mon_addr[d0+k] !== ref_addr(32'h0, 2, 16, k) || mon_slot[d0+k] !== ref_slot(2, k)) begin
        n_fail++; $display("FAIL ring_frame%0d: got addr=%h slot=%0d, expected addr=%h slot=%0d", k,
                           mon_addr[d0+k], mon_slot[d0+k], ref_addr(32'h0, 2, 16, k), ref_slot(2, k)); end
    end
    n_checks++; if (frame_cnt !== 16'd5) begin
      n_fail++; $display("FAIL ring_frame_cnt: got %0d, expected 5", frame_cnt); end
  endtask

  task automatic test_backpressure();
    int i0, d0, v0, r0, s0;
    i0 = irq_cnt; d0 = mon_addr.size(); v0 = valid_cyc; r0 = run_cyc; s0 = stab_viol;
    rdy_delay = 10; dma_mode = 2; ad_busy_len = 30;
    start_run(16'd1, 16'd8, 32'h2000_0003, 8'd1);
    wait_irq(i0, 2000);
    n_checks++; if (valid_cyc - v0 !== 11) begin
      n_fail++; $display("FAIL bp_valid_cycles: got %0d, expected 11", valid_cyc - v0); end
    n_checks++; if (stab_viol !== s0) begin
      n_fail++; $display("FAIL bp_desc_stable: got %0d unstable cycles, expected 0", stab_viol - s0); end
    n_checks++; if (mon_addr.size() !== d0 + 1 || mon_addr[mon_addr.size()-1] !== 32'h2000_0000 ||
                    mon_bytes[mon_bytes.size()-1] !== 32'd32) begin
      n_fail++; $display("FAIL bp_desc: got %0d desc last (%h,%0d), expected 1 desc (20000000,32)",
                         mon_addr.size() - d0, mon_addr[mon_addr.size()-1], mon_bytes[mon_bytes.size()-1]); end
    n_checks++; if (run_cyc - r0 !== ad_busy_len + 2) begin
      n_fail++; $display("FAIL bp_run_exit_on_wait: got %0d run cycles, expected %0d", run_cyc - r0, ad_busy_len + 2); end
    n_checks++; if (frame_cnt !== 16'd1 || err !== 2'b00 || irq_cnt !== i0 + 1) begin
      n_fail++; $display("FAIL bp_end: frame_cnt=%0d err=%b irqs=%0d, expected 1 00 1", frame_cnt, err, irq_cnt - i0); end
    ad_busy_len = 0;
  endtask

  task automatic test_abort();
    int i0, d0;
    i0 = irq_cnt; d0 = mon_addr.size();
    rdy_delay = 0; dma_mode = 1; ad_busy_len = 0;
    start_run(16'd0, 16'd64, 32'h8000_0000, 8'd3);
    for (int i = 0; i < 2000 && !(mon_addr.size() >= d0 + 2 && ad_control[0]); i++) @(negedge clk_200m);
    pulse_abort();
    wait_irq(i0, 2000);
    n_checks++; if (frame_cnt !== 16'd2 || ad_control[0] !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_end: frame_cnt=%0d ad_ctl=%b busy=%b, expected 2 0 0", frame_cnt, ad_control[0], busy); end
    n_checks++; if (irq_cnt !== i0 + 1 || err !== 2'b00) begin
      n_fail++; $display("FAIL abort_irq: irqs=%0d err=%b, expected 1 00", irq_cnt - i0, err); end
    repeat (60) @(negedge clk_200m);
    n_checks++; if (mon_addr.size() !== d0 + 2) begin
      n_fail++; $display("FAIL abort_no_third_desc: got %0d desc, expected 2", mon_addr.size() - d0); end
  endtask

  task automatic test_timeout();
    int i0, d0, r0;
    i0 = irq_cnt; d0 = mon_addr.size(); r0 = run_cyc;
    rdy_delay = 0; dma_mode = 0; ad_busy_len = 0;
    start_run(16'd2, 16'd4, 32'h0000_0100, 8'd2);
    wait_irq(i0, 1000);
    n_checks++; if (err !== 2'b10) begin
      n_fail++; $display("FAIL timeout_err: got %b, expected 10", err); end
    n_checks++; if (run_cyc - r0 !== 100) begin
      n_fail++; $display("FAIL timeout_run_cycles: got %0d, expected 100", run_cyc - r0); end
    n_checks++; if (frame_cnt !== 16'd0 || ad_control[0] !== 1'b0 || mon_addr.size() !== d0 + 1) begin
      n_fail++; $display("FAIL timeout_end: frame_cnt=%0d ad_ctl=%b desc=%0d, expected 0 0 1",
                         frame_cnt, ad_control[0], mon_addr.size() - d0); end
    n_checks++; if (irq_cnt !== i0 + 1) begin
      n_fail++; $display("FAIL timeout_irq: got %0d pulses, expected 1", irq_cnt - i0); end
    dma_mode = 1;
  endtask

  task automatic test_random();
    int i0, d0, nf, len, sl;
    logic [31:0] base;
    for (int it = 0; it < 4; it++) begin
      nf = $urandom_range(1, 4); len = $urandom_range(1, 40); sl = $urandom_range(0, 3);
      base = $urandom;
      rdy_delay = $urandom_range(0, 3); dma_mode = $urandom_range(1, 2); ad_busy_len = 0;
      i0 = irq_cnt; d0 = mon_addr.size();
      start_run(16'(nf), 16'(len), base, 8'(sl));
      repeat (8) @(negedge clk_200m);
      @(negedge clk_200m); cfg_start = 1'b1; cfg_length = 16'd0;
      @(negedge clk_200m); cfg_start = 1'b0;
      wait_irq(i0, 5000);
      n_checks++; if (mon_addr.size() !== d0 + nf) begin
        n_fail++; $display("FAIL rand%0d_desc_count: got %0d, expected %0d", it, mon_addr.size() - d0, nf); end
      for (int k = 0; k < nf && d0 + k < mon_addr.size(); k++) begin
        n_checks++; if (mon_addr[d0+k] !== ref_addr(base, sl, len, k) || mon_bytes[d0+k] !== 32'(len * 4) ||
                        mon_slot[d0+k] !== ref_slot(sl, k)) begin
          n_fail++; $display("FAIL rand%0d_frame%0d: got (%h,%0d,%0d), expected (%h,%0d,%0d)", it, k,
                             mon_addr[d0+k], mon_bytes[d0+k], mon_slot[d0+k],
                             ref_addr(base, sl, len, k), len * 4, ref_slot(sl, k)); end
      end
      n_checks++; if (frame_cnt !== 16'(nf) || err !== 2'b00 || irq_cnt !== i0 + 1) begin
        n_fail++; $display("FAIL rand%0d_end: frame_cnt=%0d err=%b irqs=%0d, expected %0d 00 1",
                           it, frame_cnt, err, irq_cnt - i0, nf); end
    end
  endtask

  task automatic test_zero_length();
    int i0, v0;
    i0 = irq_cnt; v0 = valid_cyc;
    start_run(16'd5, 16'd0, 32'h4000_0000, 8'd2);
    wait_irq(i0, 20);
    n_checks++; if (err !== 2'b01) begin
      n_fail++; $display("FAIL zero_len_err: got %b, expected 01", err); end
    n_checks++; if (irq_cnt !== i0 + 1 || valid_cyc !== v0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_idle: irqs=%0d valid_cycles=%0d busy=%b, expected 1 0 0",
                         irq_cnt - i0, valid_cyc - v0, busy); end
  endtask

  task automatic test_monitor();
    n_checks++; if (stab_viol !== 0) begin
      n_fail++; $display("FAIL desc_stability: got %0d unstable cycles, expected 0", stab_viol); end
    n_checks++; if (gap_viol !== 0) begin
      n_fail++; $display("FAIL min_gap: got %0d short gaps, expected 0", gap_viol); end
  endtask

  task automatic test_async_reset();
    int d0;
    d0 = mon_addr.size();
    rdy_delay = 0; dma_mode = 1; ad_busy_len = 0;
    start_run(16'd0, 16'd8, 32'h0000_4000, 8'd2);
    for (int i = 0; i < 2000 && !(mon_addr.size() >= d0 + 2 && ad_control[0]); i++) @(negedge clk_200m);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (ad_control !== 8'h00 || desc_valid !== 1'b0 || busy !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_ctrl: ad_ctl=%h valid=%b busy=%b irq=%b, expected all 0",
                         ad_control, desc_valid, busy, irq); end
    n_checks++; if (frame_cnt !== 16'd0 || slot_idx !== 8'd0 || err !== 2'b00 ||
                    desc_addr !== 32'd0 || desc_bytes !== 32'd0 || ad_length !== 16'd0) begin
      n_fail++; $display("FAIL async_reset_data: frame_cnt=%0d slot=%0d err=%b addr=%h bytes=%h ad_len=%h, expected 0",
                         frame_cnt, slot_idx, err, desc_addr, desc_bytes, ad_length); end
    @(negedge clk_200m); rst_n = 1'b1;
    repeat (30) @(negedge clk_200m);
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_stays_idle: busy=%b, expected 0", busy); end
  endtask

  initial begin
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_frames = '0; cfg_length = '0;
    cfg_base_addr = '0; cfg_ring_slots = '0;
    test_reset();
    test_normal();
    test_ring_wrap();
    test_backpressure();
    test_abort();
    test_timeout();
    test_random();
    test_zero_length();
    test_monitor();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ad_capture_sched.md
Name: ad_capture_sched

Overview:
- Frame-level sequencer for the AD capture → FIFO → Avalon-ST DMA → DDR3 path.
- On a software start it runs N frames. For each frame it:
  - posts one DMA write descriptor (DDR3 address, byte count) to the DMA descriptor port;
  - arms the AD source through its control/length inputs;
  - waits for both AD completion and DMA completion;
  - disarms the AD source and advances a ring address.
- Sits between the CSR block and the AD source / DMA engine. Runs on the clk_200m domain.

Parameters:
- TIMEOUT_CYCLES, 24'd2000000: max clk_200m cycles in RUN before a timeout error.
- GAP_CYCLES, 8'd16: minimum idle cycles between the AD going idle and the next descriptor.
- STATUS_WAIT, 4'd2: AD status code meaning "frame sent, waiting for disarm".
- STATUS_IDLE, 4'd0: AD status code meaning idle.

Ports:
- clk_200m in 1: clock.
- rst_n in 1: reset, asynchronous, active-low.
- cfg_start in 1: single-cycle pulse that starts a run.
- cfg_abort in 1: single-cycle pulse that stops after the current frame.
- cfg_frames in 16: number of frames per run; 0 = run until abort.
- cfg_length in 16: 32-bit words per frame; must be nonzero.
- cfg_base_addr in 32: DDR3 byte base address of the ring; bits [1:0] ignored.
- cfg_ring_slots in 8: number of ring slots; 0 is treated as 1.
- ad_control out 8: to the AD source; bit0 = start level, bits [7:1] = 0.
- ad_length out 16: to the AD source; the last ad_cnt index.
- ad_status in 4: AD state, already synchronised.
- desc_valid out 1: descriptor valid.
- desc_ready in 1: descriptor accepted.
- desc_addr out 32: frame write address.
- desc_bytes out 32: frame byte count.
- dma_done in 1: single-cycle pulse when the DMA completes a descriptor.
- busy out 1: high whenever the state is not IDLE.
- frame_cnt out 16: frames completed in the current run.
- slot_idx out 8: current ring slot.
- err out 2: sticky error. 01 = zero length, 10 = timeout. Cleared by the next cfg_start.
- irq out 1: one-cycle pulse at the end of a run (normal, abort or error).

Behaviour:
- Reset values: all outputs 0 and state IDLE. This includes ad_control = 0, desc_valid = 0, err = 0.
- Config latching: cfg_* are captured on cfg_start in IDLE and held for the whole run. cfg_start outside IDLE is ignored.
- IDLE → DESC on cfg_start, with these actions:
  - clear err, frame_cnt and slot_idx;
  - set addr = {cfg_base_addr[31:2], 2'b00};
  - if cfg_length == 0: set err = 01, pulse irq next cycle, stay in IDLE.
- DESC:
  - desc_valid = 1 with stable desc_addr = addr and desc_bytes = {14'b0, length, 2'b00}.
  - On desc_valid & desc_ready (same cycle) → RUN.
  - Abort while in DESC is recorded (sticky abort_req) but never drops valid before the handshake.
- RUN:
  - ad_control[0] = 1; ad_length = length - 1, because the source sends indices 0..ad_length, i.e. `length` words.
  - dma_done sets a sticky done_seen flag. A dma_done in any other state is ignored.
  - A timeout counter increments each cycle.
  - Exit to STOP when ad_status == STATUS_WAIT and (done_seen or dma_done this cycle).
  - If the counter reaches TIMEOUT_CYCLES first: set err = 10, then STOP.
- STOP:
  - ad_control[0] = 0.
  - Wait for ad_status == STATUS_IDLE, then GAP.
  - On entry: frame_cnt += 1 unless the exit from RUN was a timeout.
- GAP: count GAP_CYCLES, then:
  - if err != 0, abort_req, or (cfg_frames != 0 and frame_cnt == cfg_frames) → IDLE and pulse irq;
  - else advance the ring and go to DESC.
- Ring advance:
  - slot_idx + 1 == ring_slots → slot_idx = 0, addr = base;
  - else slot_idx += 1, addr += length*4 (32-bit wrap; no overflow check).
- Abort:
  - cfg_abort in RUN, STOP or GAP sets abort_req. The current frame always completes cleanly, with no truncation of the AD stream.
  - Abort in IDLE is ignored. abort_req clears on entry to IDLE.
- Simultaneous events:
  - cfg_abort and the RUN exit condition in the same cycle: the frame still counts.
  - dma_done arriving before the AD reaches WAIT is valid; the sticky flag covers it.
- frame_cnt saturates at 16'hFFFF in infinite mode; the ring keeps wrapping.
- Async reset mid-run drops ad_control[0] immediately, which returns the AD source to idle. Any descriptor already accepted by the DMA is not recalled.

Test Plan:
- Normal run:
  - Stimulus: cfg_frames = 3, length = 256, base = 0x1000_0000, slots = 4; DMA model pulses dma_done 5 cycles after the AD reaches WAIT.
  - Expected: descriptors (0x1000_0000, 1024), (0x1000_0400, 1024), (0x1000_0800, 1024); ad_length = 255; frame_cnt = 3; one irq; err = 0.
- Ring wrap:
  - Stimulus: frames = 5, slots = 2, length = 16, base = 0.
  - Expected: addresses 0x0, 0x40, 0x0, 0x40, 0x0; slot_idx sequence 0,1,0,1,0.
- Early DMA done and descriptor backpressure:
  - Stimulus: dma_done before AD WAIT; desc_ready held low 10 cycles.
  - Expected: desc_valid and desc_addr stay stable for the 10 cycles; RUN exits when the AD reaches WAIT; frame counted.
- Abort:
  - Stimulus: frames = 0 (infinite); cfg_abort mid-frame 2.
  - Expected: frame 2 completes; ad_control[0] falls; frame_cnt = 2; irq; no third descriptor.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 100; DMA never signals done.
  - Expected: err = 10 after 100 RUN cycles; ad_control[0] = 0; frame_cnt = 0; irq.
- Zero length and reset:
  - Stimulus: cfg_length = 0.
  - Expected: err = 01; irq; no desc_valid.
  - Stimulus: rst_n low during RUN.
  - Expected: all outputs 0 asynchronously.
